// File: rtl/vend_txn_controller.sv
// vend_txn_controller: transaction sequencer for a 3-product vending machine.
// Accumulates coin credit, validates a product choice against the price table,
// runs a one-hot dispense handshake and then a change handshake.
// Optional feature: define VEND_TIMEOUT_EN to refund credit automatically after
// TIMEOUT_CYC idle cycles in COLLECT; without it credit is held indefinitely.
module vend_txn_controller #(
  parameter int CREDIT_W    = 8,
  parameter int PRICE_A     = 25,
  parameter int PRICE_B     = 50,
  parameter int PRICE_C     = 35,
  parameter int MAX_CREDIT  = 200,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [3:0]          coin_val,
  output logic                coin_accept,
  output logic                coin_reject,
  input  logic                choice_valid,
  input  logic [1:0]          choice,
  output logic                sel_nack,
  output logic [2:0]          disp_req,
  input  logic                disp_ack,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  state_t state;

  // Latched price of the product being dispensed.
  logic [CREDIT_W-1:0] price_q;

  // Coin code to cents; invalid codes map to zero.
  function automatic logic [CREDIT_W-1:0] coin_cents(input logic [3:0] code);
    logic [CREDIT_W-1:0] v;
    case (code)
      4'd1:    v = CREDIT_W'(5);
      4'd2:    v = CREDIT_W'(10);
      4'd3:    v = CREDIT_W'(25);
      4'd4:    v = CREDIT_W'(100);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Only codes 1..4 denote real coins.
  function automatic logic coin_code_ok(input logic [3:0] code);
    return (code >= 4'd1) && (code <= 4'd4);
  endfunction

  // Product index to price; index 3 is not a product and yields zero.
  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] sel);
    logic [CREDIT_W-1:0] p;
    case (sel)
      2'd0:    p = CREDIT_W'(PRICE_A);
      2'd1:    p = CREDIT_W'(PRICE_B);
      2'd2:    p = CREDIT_W'(PRICE_C);
      default: p = '0;
    endcase
    return p;
  endfunction

  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_ok;
  logic [CREDIT_W-1:0] remainder;

  // Coin admission, selection affordability and post-dispense remainder.
  always_comb begin
    coin_sum  = {1'b0, credit} + {1'b0, coin_cents(coin_val)};
    coin_fits = coin_code_ok(coin_val) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    sel_price = price_of(choice);
    sel_ok    = (choice != 2'd3) && (credit >= sel_price);
    remainder = credit - price_q;
  end

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  // Count of consecutive strobe-free cycles spent in COLLECT.
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      credit       <= '0;
      price_q      <= '0;
      coin_accept  <= 1'b0;
      coin_reject  <= 1'b0;
      sel_nack     <= 1'b0;
      disp_req     <= 3'b000;
      change_valid <= 1'b0;
      change_amt   <= '0;
      busy         <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
      sel_nack    <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (coin_valid) begin
            // A coin wins over a simultaneous selection.
            if (coin_fits) begin
              credit      <= coin_sum[CREDIT_W-1:0];
              coin_accept <= 1'b1;
              state       <= COLLECT;
            end else begin
              coin_reject <= 1'b1;
            end
            if (choice_valid) sel_nack <= 1'b1;
          end else if (choice_valid) begin
            if (sel_ok) begin
              disp_req <= 3'b001 << choice;
              price_q  <= sel_price;
              busy     <= 1'b1;
              state    <= DISPENSE;
            end else begin
              sel_nack <= 1'b1;
            end
          end
`ifdef VEND_TIMEOUT_EN
          if (coin_valid || choice_valid || (state != COLLECT)) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            // Idle too long: refund the whole credit as change.
            tmo_cnt      <= '0;
            change_amt   <= credit;
            change_valid <= 1'b1;
            busy         <= 1'b1;
            state        <= CHANGE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        DISPENSE: begin
          if (coin_valid)   coin_reject <= 1'b1;
          if (choice_valid) sel_nack    <= 1'b1;
          if (disp_ack) begin
            disp_req <= 3'b000;
            credit   <= remainder;
            if (remainder != '0) begin
              change_amt   <= remainder;
              change_valid <= 1'b1;
              state        <= CHANGE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        CHANGE: begin
          if (coin_valid)   coin_reject <= 1'b1;
          if (choice_valid) sel_nack    <= 1'b1;
          if (change_ack) begin
            change_valid <= 1'b0;
            change_amt   <= '0;
            credit       <= '0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_txn_controller.sv
// Testbench for vend_txn_controller: directed transactions checked against a
// transaction-level model on every cycle, plus literal spot checks.
// Define VEND_TIMEOUT_EN for both bench and RTL to exercise the refund timeout.
module tb_vend_txn_controller;

  localparam int CW   = 8;
  localparam int MAXC = 200;
  localparam int TCYC = 8;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          coin_valid = 1'b0;
  logic [3:0]    coin_val = 4'd0;
  logic          coin_accept;
  logic          coin_reject;
  logic          choice_valid = 1'b0;
  logic [1:0]    choice = 2'd0;
  logic          sel_nack;
  logic [2:0]    disp_req;
  logic          disp_ack = 1'b0;
  logic          change_valid;
  logic [CW-1:0] change_amt;
  logic          change_ack = 1'b0;
  logic [CW-1:0] credit;
  logic          busy;

  always #5 clock = ~clock;

  vend_txn_controller #(
    .CREDIT_W(CW), .PRICE_A(25), .PRICE_B(50), .PRICE_C(35),
    .MAX_CREDIT(MAXC), .TIMEOUT_CYC(TCYC)
  ) dut (
    .clock(clock), .rst(rst),
    .coin_valid(coin_valid), .coin_val(coin_val),
    .coin_accept(coin_accept), .coin_reject(coin_reject),
    .choice_valid(choice_valid), .choice(choice), .sel_nack(sel_nack),
    .disp_req(disp_req), .disp_ack(disp_ack),
    .change_valid(change_valid), .change_amt(change_amt), .change_ack(change_ack),
    .credit(credit), .busy(busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int price_tbl [3]  = '{25, 50, 35};
  int coin_tbl  [16] = '{0, 5, 10, 25, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  int m_credit = 0;   // credit in cents
  int m_disp   = -1;  // product being dispensed, -1 when none
  int m_price  = 0;
  int m_change = 0;   // outstanding change, 0 when none
  int m_idle   = 0;
  bit e_acc = 0, e_rej = 0, e_nack = 0;

  always @(posedge clock or posedge rst) begin
    if (rst) begin
      m_credit = 0; m_disp = -1; m_price = 0; m_change = 0; m_idle = 0;
      e_acc = 0; e_rej = 0; e_nack = 0;
    end else begin
      e_acc = 0; e_rej = 0; e_nack = 0;
      if (m_disp >= 0) begin
        if (coin_valid)   e_rej  = 1;
        if (choice_valid) e_nack = 1;
        if (disp_ack) begin
          m_credit = m_credit - m_price;
          m_disp   = -1;
          m_change = m_credit;
        end
      end else if (m_change > 0) begin
        if (coin_valid)   e_rej  = 1;
        if (choice_valid) e_nack = 1;
        if (change_ack) begin
          m_change = 0;
          m_credit = 0;
        end
      end else begin
        if (coin_valid) begin
          int v;
          v = coin_tbl[coin_val];
          if (v > 0 && m_credit + v <= MAXC) begin
            m_credit = m_credit + v;
            e_acc = 1;
          end else begin
            e_rej = 1;
          end
          if (choice_valid) e_nack = 1;
        end else if (choice_valid) begin
          if (choice == 2'd3 || m_credit < price_tbl[choice]) begin
            e_nack = 1;
          end else begin
            m_disp  = int'(choice);
            m_price = price_tbl[choice];
          end
        end
`ifdef VEND_TIMEOUT_EN
        if (coin_valid || choice_valid) begin
          m_idle = 0;
        end else if (m_credit > 0) begin
          m_idle++;
          if (m_idle == TCYC) begin
            m_change = m_credit;
            m_idle = 0;
          end
        end
`endif
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (!rst) begin
      chk("coin_accept", int'(coin_accept), int'(e_acc));
      chk("coin_reject", int'(coin_reject), int'(e_rej));
      chk("sel_nack", int'(sel_nack), int'(e_nack));
      chk("disp_req", int'(disp_req), (m_disp < 0) ? 0 : (1 << m_disp));
      chk("change_valid", int'(change_valid), (m_change > 0) ? 1 : 0);
      if (change_valid) chk("change_amt", int'(change_amt), m_change);
      chk("credit", int'(credit), m_credit);
      chk("busy", int'(busy), (m_disp >= 0 || m_change > 0) ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic coin(input logic [3:0] v);
    coin_valid = 1'b1; coin_val = v;
    cyc();
    coin_valid = 1'b0; coin_val = 4'd0;
  endtask

  task automatic pick(input logic [1:0] c);
    choice_valid = 1'b1; choice = c;
    cyc();
    choice_valid = 1'b0; choice = 2'd0;
  endtask

  task automatic ack_disp();
    disp_ack = 1'b1;
    cyc();
    disp_ack = 1'b0;
  endtask

  task automatic ack_change();
    change_ack = 1'b1;
    cyc();
    change_ack = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #2;
    chk("reset_credit", int'(credit), 0);
    chk("reset_disp_req", int'(disp_req), 0);
    chk("reset_change_valid", int'(change_valid), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    cyc();

    // Stray acks while idle must be ignored.
    ack_disp();
    ack_change();
    chk("stray_ack_credit", int'(credit), 0);

    // 25c buys A exactly, no change.
    coin(4'd3);
    chk("t1_accept", int'(coin_accept), 1);
    chk("t1_credit", int'(credit), 25);
    pick(2'd0);
    chk("t1_disp_req", int'(disp_req), 3'b001);
    chk("t1_busy", int'(busy), 1);
    cyc();
    chk("t1_disp_held", int'(disp_req), 3'b001);
    ack_disp();
    chk("t1_disp_done", int'(disp_req), 0);
    chk("t1_credit_end", int'(credit), 0);
    chk("t1_no_change", int'(change_valid), 0);
    chk("t1_idle", int'(busy), 0);

    // 100c buys C, 65c change.
    coin(4'd4);
    pick(2'd2);
    chk("t2_disp_req", int'(disp_req), 3'b100);
    ack_disp();
    chk("t2_change_valid", int'(change_valid), 1);
    chk("t2_change_amt", int'(change_amt), 65);
    cyc();
    chk("t2_change_held", int'(change_amt), 65);
    ack_change();
    chk("t2_change_done", int'(change_valid), 0);
    chk("t2_credit_end", int'(credit), 0);

    // Short credit and invalid choice are refused.
    coin(4'd2);
    pick(2'd1);
    chk("t3_nack_short", int'(sel_nack), 1);
    chk("t3_credit", int'(credit), 10);
    pick(2'd3);
    chk("t3_nack_invalid", int'(sel_nack), 1);
    chk("t3_no_disp", int'(disp_req), 0);

    // Build to 150c, then an overflowing coin and a bad code are refused.
    coin(4'd4);
    coin(4'd3);
    coin(4'd2);
    coin(4'd1);
    chk("t4_credit150", int'(credit), 150);
    coin(4'd4);
    chk("t4_reject_over", int'(coin_reject), 1);
    chk("t4_credit_kept", int'(credit), 150);
    coin(4'd7);
    chk("t4_reject_code", int'(coin_reject), 1);
    coin(4'd4);
    coin(4'd3);
    coin(4'd3);
    chk("t4_credit_max", int'(credit), 200);
    coin(4'd1);
    chk("t4_reject_at_max", int'(coin_reject), 1);

    // Buy B from 200c; coins and choices while busy are refused.
    pick(2'd1);
    chk("t5_disp_b", int'(disp_req), 3'b010);
    coin(4'd3);
    chk("t5_reject_busy", int'(coin_reject), 1);
    pick(2'd0);
    chk("t5_nack_busy", int'(sel_nack), 1);
    ack_disp();
    chk("t5_change_amt", int'(change_amt), 150);
    coin(4'd1);
    chk("t5_reject_change", int'(coin_reject), 1);
    ack_change();
    chk("t5_idle_credit", int'(credit), 0);

    // Coin and choice in the same cycle: coin taken, choice refused.
    coin_valid = 1'b1; coin_val = 4'd3; choice_valid = 1'b1; choice = 2'd0;
    cyc();
    coin_valid = 1'b0; coin_val = 4'd0; choice_valid = 1'b0;
    chk("t5_simul_accept", int'(coin_accept), 1);
    chk("t5_simul_nack", int'(sel_nack), 1);
    chk("t5_simul_no_disp", int'(disp_req), 0);
    pick(2'd0);
    ack_disp();
    chk("t5_simul_end", int'(credit), 0);

    // Idle in COLLECT: timeout refund or indefinite hold.
    coin(4'd2);
`ifdef VEND_TIMEOUT_EN
    begin
      int waited;
      waited = 0;
      while (!change_valid && waited < 20) begin
        cyc();
        waited++;
      end
      chk("t6_timeout_seen", int'(change_valid), 1);
      chk("t6_timeout_cycles", waited, TCYC);
      chk("t6_timeout_amt", int'(change_amt), 10);
    end
    ack_change();
    chk("t6_timeout_credit", int'(credit), 0);
    coin(4'd4);
`else
    repeat (TCYC + 4) cyc();
    chk("t6_hold_no_change", int'(change_valid), 0);
    chk("t6_hold_credit", int'(credit), 10);
    coin(4'd4);
`endif

    // Reset while dispensing B drops everything at once.
    pick(2'd1);
    chk("t6_disp_b", int'(disp_req), 3'b010);
    #4;
    rst = 1'b1;
    #1;
    chk("t6_rst_disp_req", int'(disp_req), 0);
    chk("t6_rst_credit", int'(credit), 0);
    chk("t6_rst_busy", int'(busy), 0);
    repeat (2) @(posedge clock);
    #2;
    rst = 1'b0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
